data_bus_if: RTL and testbench
==============================

DATA_BUS_IF -- requirements
Module: data_bus_if

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the number of BUSY cycles without ack before abort (used only when BUS_TIMEOUT_EN is defined).
REQ-002 SHALL have ports in this order:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_ce_i  in  1  access request from the mem stage.
- cpu_addr_i  in  32  byte address.
- cpu_data_i  in  32  store data, byte-replicated by the mem stage.
- cpu_we_i  in  1  1 = store, 0 = load.
- cpu_sel_i  in  4  byte lanes, with bit 3 = addr[1:0]==0.
- cpu_data_o  out  32  load data returned to the mem stage.
- stall_i  in  6  pipeline stall vector; bit 0 = PC stage.
- flush_i  in  1  pipeline flush.
- stallreq  out  1  stall request to the pipeline controller.
- wishbone_data_i  in  32  bus read data.
- wishbone_ack_i  in  1  bus acknowledge.
- wishbone_addr_o  out  32  bus address.
- wishbone_data_o  out  32  bus write data.
- wishbone_we_o  out  1  bus write enable.
- wishbone_sel_o  out  4  bus byte select.
- wishbone_stb_o  out  1  bus strobe.
- wishbone_cyc_o  out  1  bus cycle.
- bus_err_o  out  1  one-cycle timeout pulse (port present only with BUS_TIMEOUT_EN).

Function
REQ-003 SHALL implement the FSM IDLE, BUSY and WAIT_FOR_STALL; the FSM and all wishbone_* outputs are registered.
REQ-004 In IDLE, when cpu_ce_i=1 and flush_i=0, the block SHALL load addr, data, we and sel onto the bus, set stb=cyc=1 at the next edge, and go to BUSY.
REQ-005 stallreq SHALL be combinational:
- 1 in IDLE when cpu_ce_i=1 and flush_i=0.
- 1 in BUSY while wishbone_ack_i=0.
- 0 otherwise.
REQ-006 In BUSY, the bus outputs SHALL hold stable until ack.
REQ-007 On ack in BUSY, the block SHALL:
- clear all wishbone_* outputs to 0 at the next edge.
- capture wishbone_data_i into rd_buf when we=0.
- go to WAIT_FOR_STALL if stall_i[0]=1, otherwise to IDLE.
REQ-008 cpu_data_o SHALL be:
- wishbone_data_i in BUSY with ack and we=0.
- rd_buf in WAIT_FOR_STALL.
- 0 otherwise.
REQ-009 In WAIT_FOR_STALL, stallreq SHALL be 0; the block SHALL go to IDLE when stall_i[0]=0.
REQ-010 flush_i=1 in any state SHALL drop stb/cyc, zero the bus outputs and go to IDLE at the next edge; flush SHALL win over a simultaneous ack, and that data is discarded.
REQ-011 Minimum access latency SHALL be 2 cycles from request to data (request edge plus ack cycle); a back-to-back request SHALL NOT issue in the same cycle as the previous ack.
REQ-012 wishbone_data_o and wishbone_sel_o SHALL pass through unchanged; no lane steering is done in this block.

Reset
REQ-013 rst=1 at a clock edge SHALL force IDLE, rd_buf=0, all wishbone_* outputs 0 and bus_err_o=0; stallreq and cpu_data_o then evaluate to 0.
REQ-014 Reset during BUSY SHALL abandon the transaction, and a late ack SHALL be ignored.

Configuration
REQ-015 With BUS_TIMEOUT_EN defined:
- an 8+ bit counter SHALL clear on entry to BUSY and increment each BUSY cycle.
- at TIMEOUT_CYCLES without ack, the block SHALL abort as in REQ-007 with data 0 and pulse bus_err_o for 1 cycle.
REQ-016 Without BUS_TIMEOUT_EN, there SHALL be no counter and no bus_err_o; BUSY waits indefinitely.

Structure
REQ-017 State encodings, WriteEnable/ChipEnable, RegBus and the stall-vector width SHALL live in the shared defines file.
REQ-018 The timeout counter SHALL be sub-module bus_watchdog, instantiated only under BUS_TIMEOUT_EN; everything else stays flat.

Verification
REQ-019 Load with ack after 3 cycles, addr 0x100, data 0xDEADBEEF, stall_i=0 -> stb/cyc high for 3 cycles; cpu_data_o=0xDEADBEEF in the ack cycle; stallreq low in the ack cycle; back to IDLE.
REQ-020 Store of sel 4'b0100 with data 0x5A5A5A5A, ack after 1 cycle -> bus shows we=1, sel=0100, data=0x5A5A5A5A; outputs zeroed the next cycle.
REQ-021 Load acked while stall_i[0]=1 for 2 more cycles -> WAIT_FOR_STALL holds cpu_data_o=rd_buf and stallreq=0; IDLE follows when stall_i[0] drops.
REQ-022 flush_i asserted coincident with ack in BUSY -> stb/cyc=0 next cycle, rd_buf unchanged, state IDLE.
REQ-023 With BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> abort after 4 BUSY cycles, bus_err_o=1 for exactly 1 cycle, cpu_data_o=0.
REQ-024 rst pulsed mid-BUSY followed by a stray ack -> all outputs 0, no state change on the ack.

Source files
------------

// File: rtl/data_bus_if_pkg.sv
// Shared definitions for the data bus interface: state encodings, enables, bus widths.
// Also holds the registered wishbone request bundle carried between the FSM and the pins.
package data_bus_if_pkg;

  localparam int RegBus = 32;
  localparam int StallW = 6;

  localparam logic WriteEnable = 1'b1;
  localparam logic ChipEnable  = 1'b1;

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    BUSY           = 2'd1,
    WAIT_FOR_STALL = 2'd2
  } bus_state_e;

  typedef struct packed {
    logic [RegBus-1:0] addr;
    logic [RegBus-1:0] dat;
    logic              we;
    logic [3:0]        sel;
    logic              stb;
    logic              cyc;
  } wb_req_t;

endpackage

// File: rtl/bus_watchdog.sv
// Counts BUSY cycles of one bus access; flags expiry in the last permitted cycle without ack.
// Latency: expire_o is combinational from the count; backpressure: none, purely observes.
module bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic busy_i,
  input  logic ack_i,
  output logic expire_o
);

  localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (busy_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // cnt_q holds the number of BUSY cycles already completed, so N-1 marks the Nth cycle.
  assign expire_o = busy_i && !ack_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/data_bus_if.sv
// Wishbone master for the mem stage, 2-cycle minimum latency; stallreq holds the pipeline until ack.
// Optional BUS_TIMEOUT_EN adds a bus_watchdog abort after TIMEOUT_CYCLES and a bus_err_o pulse.
module data_bus_if
  import data_bus_if_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ce_i,
  input  logic [RegBus-1:0] cpu_addr_i,
  input  logic [RegBus-1:0] cpu_data_i,
  input  logic              cpu_we_i,
  input  logic [3:0]        cpu_sel_i,
  output logic [RegBus-1:0] cpu_data_o,
  input  logic [StallW-1:0] stall_i,
  input  logic              flush_i,
  output logic              stallreq,
  input  logic [RegBus-1:0] wishbone_data_i,
  input  logic              wishbone_ack_i,
  output logic [RegBus-1:0] wishbone_addr_o,
  output logic [RegBus-1:0] wishbone_data_o,
  output logic              wishbone_we_o,
  output logic [3:0]        wishbone_sel_o,
  output logic              wishbone_stb_o,
  output logic              wishbone_cyc_o
`ifdef BUS_TIMEOUT_EN
  ,
  output logic              bus_err_o
`endif
);

  bus_state_e        state_q, state_d;
  wb_req_t           wb_q, wb_d;
  logic [RegBus-1:0] rd_buf_q, rd_buf_d;
  logic              timeout;
  logic              wd_start;
  logic              abort;
  logic              unused_stall;

  assign unused_stall = ^stall_i[StallW-1:1];

`ifdef BUS_TIMEOUT_EN
  logic bus_err_q;
  logic in_busy;

  assign in_busy = (state_q == BUSY);

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_bus_watchdog (
    .clk      (clk),
    .rst      (rst),
    .start_i  (wd_start),
    .busy_i   (in_busy),
    .ack_i    (wishbone_ack_i),
    .expire_o (timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= abort;
    end
  end

  assign bus_err_o = bus_err_q;
`else
  logic unused_cfg;

  assign timeout    = 1'b0;
  assign unused_cfg = (TIMEOUT_CYCLES == 0) ^ wd_start ^ abort;
`endif

  always_comb begin
    state_d    = state_q;
    wb_d       = wb_q;
    rd_buf_d   = rd_buf_q;
    stallreq   = 1'b0;
    cpu_data_o = '0;
    wd_start   = 1'b0;
    abort      = 1'b0;

    case (state_q)
      IDLE: begin
        if ((cpu_ce_i == ChipEnable) && !flush_i) begin
          stallreq = 1'b1;
          wb_d     = '{addr: cpu_addr_i, dat: cpu_data_i, we: cpu_we_i,
                       sel: cpu_sel_i, stb: 1'b1, cyc: 1'b1};
          wd_start = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (wishbone_ack_i) begin
          if (wb_q.we != WriteEnable) begin
            cpu_data_o = wishbone_data_i;
            rd_buf_d   = wishbone_data_i;
          end
          wb_d    = '0;
          state_d = stall_i[0] ? WAIT_FOR_STALL : IDLE;
        end else begin
          stallreq = 1'b1;
          if (timeout) begin
            wb_d     = '0;
            rd_buf_d = '0;
            abort    = 1'b1;
            state_d  = stall_i[0] ? WAIT_FOR_STALL : IDLE;
          end
        end
      end
      WAIT_FOR_STALL: begin
        cpu_data_o = rd_buf_q;
        if (!stall_i[0]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush beats everything, including an ack landing in the same cycle.
    if (flush_i) begin
      state_d  = IDLE;
      wb_d     = '0;
      rd_buf_d = rd_buf_q;
      abort    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wb_q     <= '0;
      rd_buf_q <= '0;
    end else begin
      state_q  <= state_d;
      wb_q     <= wb_d;
      rd_buf_q <= rd_buf_d;
    end
  end

  assign wishbone_addr_o = wb_q.addr;
  assign wishbone_data_o = wb_q.dat;
  assign wishbone_we_o   = wb_q.we;
  assign wishbone_sel_o  = wb_q.sel;
  assign wishbone_stb_o  = wb_q.stb;
  assign wishbone_cyc_o  = wb_q.cyc;

endmodule

// File: tb/tb_data_bus_if.sv
// Directed bench for data_bus_if: transaction-level model checked every cycle plus literal spot checks.
// With BUS_TIMEOUT_EN the DUT runs with TIMEOUT_CYCLES=4 and the abort path is exercised.
module tb_data_bus_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_i;
  logic        cpu_we_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_o;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        stallreq;
  logic [31:0] wishbone_data_i;
  logic        wishbone_ack_i;
  logic [31:0] wishbone_addr_o;
  logic [31:0] wishbone_data_o;
  logic        wishbone_we_o;
  logic [3:0]  wishbone_sel_o;
  logic        wishbone_stb_o;
  logic        wishbone_cyc_o;
`ifdef BUS_TIMEOUT_EN
  logic        bus_err_o;
  localparam int TO = 4;
`else
  localparam int TO = 0;
`endif

  always #5 clk = ~clk;

  data_bus_if #(.TIMEOUT_CYCLES(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .cpu_ce_i        (cpu_ce_i),
    .cpu_addr_i      (cpu_addr_i),
    .cpu_data_i      (cpu_data_i),
    .cpu_we_i        (cpu_we_i),
    .cpu_sel_i       (cpu_sel_i),
    .cpu_data_o      (cpu_data_o),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .stallreq        (stallreq),
    .wishbone_data_i (wishbone_data_i),
    .wishbone_ack_i  (wishbone_ack_i),
    .wishbone_addr_o (wishbone_addr_o),
    .wishbone_data_o (wishbone_data_o),
    .wishbone_we_o   (wishbone_we_o),
    .wishbone_sel_o  (wishbone_sel_o),
    .wishbone_stb_o  (wishbone_stb_o),
    .wishbone_cyc_o  (wishbone_cyc_o)
`ifdef BUS_TIMEOUT_EN
    ,
    .bus_err_o       (bus_err_o)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding access, an optional held result, a read buffer.
  bit          m_ok = 1'b0;
  bit          m_active, m_hold, m_err;
  logic [31:0] m_addr, m_data, m_buf;
  bit          m_we;
  logic [3:0]  m_sel;
  int          m_age;

  always @(posedge clk) begin
    if (rst) begin
      m_ok = 1'b1; m_active = 1'b0; m_hold = 1'b0; m_err = 1'b0; m_buf = '0;
    end else if (m_ok) begin
      m_err = 1'b0;
      if (flush_i) begin
        m_active = 1'b0;
        m_hold   = 1'b0;
      end else if (m_active) begin
        m_age++;
        if (wishbone_ack_i) begin
          m_active = 1'b0;
          if (!m_we) m_buf = wishbone_data_i;
          m_hold = stall_i[0];
        end else if (TO != 0 && m_age >= TO) begin
          m_active = 1'b0;
          m_buf    = '0;
          m_err    = 1'b1;
          m_hold   = stall_i[0];
        end
      end else if (m_hold) begin
        m_hold = stall_i[0];
      end else if (cpu_ce_i) begin
        m_active = 1'b1;
        m_age    = 0;
        m_addr   = cpu_addr_i;
        m_data   = cpu_data_i;
        m_we     = cpu_we_i;
        m_sel    = cpu_sel_i;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("m_stb",   32'(wishbone_stb_o), 32'(m_active));
      check("m_cyc",   32'(wishbone_cyc_o), 32'(m_active));
      check("m_addr",  wishbone_addr_o, m_active ? m_addr : 32'h0);
      check("m_wdat",  wishbone_data_o, m_active ? m_data : 32'h0);
      check("m_we",    32'(wishbone_we_o), 32'(m_active && m_we));
      check("m_sel",   32'(wishbone_sel_o), m_active ? 32'(m_sel) : 32'h0);
      check("m_stall", 32'(stallreq),
            m_active ? 32'(!wishbone_ack_i) : 32'(!m_hold && cpu_ce_i && !flush_i));
      check("m_rdat",  cpu_data_o,
            (m_active && wishbone_ack_i && !m_we) ? wishbone_data_i : (m_hold ? m_buf : 32'h0));
`ifdef BUS_TIMEOUT_EN
      check("m_err",   32'(bus_err_o), 32'(m_err));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic we, input logic [3:0] s);
    cpu_ce_i = 1'b1; cpu_addr_i = a; cpu_data_i = d; cpu_we_i = we; cpu_sel_i = s;
  endtask

  initial begin
    rst = 1'b1; cpu_ce_i = 0; cpu_addr_i = 0; cpu_data_i = 0; cpu_we_i = 0; cpu_sel_i = 0;
    stall_i = 0; flush_i = 0; wishbone_data_i = 0; wishbone_ack_i = 0;
    tick(); tick();
    rst = 1'b0;
    mid();
    check("rst_stb", 32'(wishbone_stb_o), 32'h0);
    check("rst_stallreq", 32'(stallreq), 32'h0);
    check("rst_rdat", cpu_data_o, 32'h0);
    tick();

    // Load, ack in third BUSY cycle.
    issue(32'h100, 32'h0, 1'b0, 4'hF);
    mid(); check("ld_req_stall", 32'(stallreq), 32'h1); check("ld_req_stb", 32'(wishbone_stb_o), 32'h0);
    tick();
    cpu_ce_i = 0;
    mid(); check("ld_b1_stb", 32'(wishbone_stb_o), 32'h1); check("ld_b1_addr", wishbone_addr_o, 32'h100);
    tick();
    mid(); check("ld_b2_stb", 32'(wishbone_stb_o), 32'h1);
    tick();
    wishbone_ack_i = 1; wishbone_data_i = 32'hDEADBEEF;
    mid(); check("ld_ack_rdat", cpu_data_o, 32'hDEADBEEF); check("ld_ack_stall", 32'(stallreq), 32'h0);
    check("ld_b3_cyc", 32'(wishbone_cyc_o), 32'h1);
    tick();
    wishbone_ack_i = 0; wishbone_data_i = 0;
    mid(); check("ld_done_stb", 32'(wishbone_stb_o), 32'h0); check("ld_done_rdat", cpu_data_o, 32'h0);
    tick();

    // Store, single-lane, ack in first BUSY cycle.
    issue(32'h204, 32'h5A5A5A5A, 1'b1, 4'b0100);
    tick();
    cpu_ce_i = 0; wishbone_ack_i = 1;
    mid(); check("st_we", 32'(wishbone_we_o), 32'h1); check("st_sel", 32'(wishbone_sel_o), 32'h4);
    check("st_wdat", wishbone_data_o, 32'h5A5A5A5A); check("st_rdat", cpu_data_o, 32'h0);
    tick();
    wishbone_ack_i = 0;
    mid(); check("st_clr_wdat", wishbone_data_o, 32'h0); check("st_clr_sel", 32'(wishbone_sel_o), 32'h0);
    check("st_clr_we", 32'(wishbone_we_o), 32'h0);
    tick();

    // Load acked while the pipeline is stalled.
    issue(32'h300, 32'h0, 1'b0, 4'hF);
    tick();
    cpu_ce_i = 0; wishbone_ack_i = 1; wishbone_data_i = 32'h12345678; stall_i = 6'h01;
    mid(); check("wfs_ack_rdat", cpu_data_o, 32'h12345678);
    tick();
    wishbone_ack_i = 0; wishbone_data_i = 0;
    for (int i = 0; i < 2; i++) begin
      mid(); check("wfs_hold_rdat", cpu_data_o, 32'h12345678); check("wfs_hold_stall", 32'(stallreq), 32'h0);
      tick();
    end
    stall_i = 6'h00;
    mid(); check("wfs_last_rdat", cpu_data_o, 32'h12345678);
    tick();
    mid(); check("wfs_idle_rdat", cpu_data_o, 32'h0);
    tick();

    // Flush coincident with ack discards the data.
    issue(32'h400, 32'h0, 1'b0, 4'hF);
    tick();
    cpu_ce_i = 0; wishbone_ack_i = 1; flush_i = 1; wishbone_data_i = 32'hFFFF0000;
    tick();
    wishbone_ack_i = 0; flush_i = 0; wishbone_data_i = 0;
    mid(); check("fl_stb", 32'(wishbone_stb_o), 32'h0); check("fl_cyc", 32'(wishbone_cyc_o), 32'h0);
    check("fl_rdbuf", dut.rd_buf_q, 32'h12345678);
    tick();
    issue(32'h404, 32'h0, 1'b0, 4'hF); flush_i = 1;
    mid(); check("fl_idle_stall", 32'(stallreq), 32'h0);
    tick();
    cpu_ce_i = 0; flush_i = 0;
    mid(); check("fl_idle_stb", 32'(wishbone_stb_o), 32'h0);
    tick();

    // Back-to-back: request held high across the ack must not reissue that cycle.
    issue(32'h500, 32'h0, 1'b0, 4'hF);
    tick();
    wishbone_ack_i = 1; wishbone_data_i = 32'hCAFEF00D;
    mid(); check("b2b_rdat", cpu_data_o, 32'hCAFEF00D); check("b2b_ack_stall", 32'(stallreq), 32'h0);
    tick();
    wishbone_ack_i = 0; wishbone_data_i = 0; cpu_addr_i = 32'h504;
    mid(); check("b2b_gap_stb", 32'(wishbone_stb_o), 32'h0); check("b2b_gap_stall", 32'(stallreq), 32'h1);
    tick();
    cpu_ce_i = 0;
    mid(); check("b2b_2nd_addr", wishbone_addr_o, 32'h504);
    tick();
    wishbone_ack_i = 1; wishbone_data_i = 32'h0BADC0DE;
    tick();
    wishbone_ack_i = 0; wishbone_data_i = 0;
    tick();

    // Reset mid-BUSY followed by a stray ack.
    issue(32'h600, 32'h0, 1'b0, 4'hF);
    tick();
    cpu_ce_i = 0;
    tick();
    rst = 1;
    tick();
    rst = 0; wishbone_ack_i = 1; wishbone_data_i = 32'h11111111;
    mid(); check("rb_stb", 32'(wishbone_stb_o), 32'h0); check("rb_rdat", cpu_data_o, 32'h0);
    check("rb_stall", 32'(stallreq), 32'h0);
    tick();
    wishbone_ack_i = 0; wishbone_data_i = 0;
    mid(); check("rb_after_stb", 32'(wishbone_stb_o), 32'h0); check("rb_rdbuf", dut.rd_buf_q, 32'h0);
    tick();

`ifdef BUS_TIMEOUT_EN
    // No ack: abort after four BUSY cycles with a one-cycle error pulse.
    issue(32'h700, 32'h0, 1'b0, 4'hF);
    tick();
    cpu_ce_i = 0;
    for (int i = 0; i < 4; i++) begin
      mid(); check("to_busy_stb", 32'(wishbone_stb_o), 32'h1);
      tick();
    end
    mid(); check("to_stb", 32'(wishbone_stb_o), 32'h0); check("to_err", 32'(bus_err_o), 32'h1);
    check("to_rdat", cpu_data_o, 32'h0);
    tick();
    mid(); check("to_err_clr", 32'(bus_err_o), 32'h0);
    tick();
`else
    // No ack: BUSY waits indefinitely until the ack arrives.
    issue(32'h700, 32'h0, 1'b0, 4'hF);
    tick();
    cpu_ce_i = 0;
    for (int i = 0; i < 10; i++) begin
      mid(); check("wait_stb", 32'(wishbone_stb_o), 32'h1);
      tick();
    end
    wishbone_ack_i = 1; wishbone_data_i = 32'h77777777;
    mid(); check("wait_rdat", cpu_data_o, 32'h77777777);
    tick();
    wishbone_ack_i = 0; wishbone_data_i = 0;
    mid(); check("wait_done_stb", 32'(wishbone_stb_o), 32'h0);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
